// File: rtl/set_pkg.sv
// Shared mode codes and scan FSM states for the N-circle set counter.
package set_pkg;

   localparam logic [1:0] MODE_ANY   = 2'b00;
   localparam logic [1:0] MODE_ALL   = 2'b01;
   localparam logic [1:0] MODE_ODD   = 2'b10;
   localparam logic [1:0] MODE_EXACT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SCAN  = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/circle_hit.sv
// Combinational point-in-circle test: (px-cx)^2 + (py-cy)^2 <= r^2.
module circle_hit #(
   parameter int COORD_W = 4
) (
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [COORD_W-1:0] r,
   input  logic [COORD_W-1:0] px,
   input  logic [COORD_W-1:0] py,
   output logic               hit
);

   localparam int PW = 2*COORD_W + 2;
   localparam int SW = 2*(COORD_W+1) + 1;

   logic signed [COORD_W:0] dx, dy;
   logic signed [PW-1:0]    dxe, dye, dx2, dy2;
   logic [SW-1:0]           d2, r2;

   assign dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
   assign dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
   // Sign-extend before squaring so the product is formed at full width.
   assign dxe = PW'(dx);
   assign dye = PW'(dy);
   assign dx2 = dxe * dxe;
   assign dy2 = dye * dye;
   assign d2  = SW'($unsigned(dx2)) + SW'($unsigned(dy2));
   assign r2  = SW'(r) * SW'(r);
   assign hit = (d2 <= r2);

endmodule

// File: rtl/set_count_n.sv
// Scans a GRID_MAX x GRID_MAX grid and counts points matching a set
// expression over a masked subset of NUM_CIRCLES circles.
module set_count_n
   import set_pkg::*;
#(
   parameter int NUM_CIRCLES = 3,
   parameter int COORD_W     = 4,
   parameter int GRID_MAX    = 8,
   parameter int CNT_W       = $clog2(GRID_MAX*GRID_MAX+1)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               en,
   input  logic [2*COORD_W*NUM_CIRCLES-1:0]   central,
   input  logic [COORD_W*NUM_CIRCLES-1:0]     radius,
   input  logic [1:0]                         mode,
   input  logic [NUM_CIRCLES-1:0]             mask,
   input  logic [$clog2(NUM_CIRCLES+1)-1:0]   k,
   output logic                               busy,
   output logic                               valid,
   output logic [CNT_W-1:0]                   candidate
);

   localparam int KW = $clog2(NUM_CIRCLES+1);
   localparam logic [COORD_W-1:0] LAST = COORD_W'(GRID_MAX);

   state_t                             state;
   logic [2*COORD_W*NUM_CIRCLES-1:0]   cen_q;
   logic [COORD_W*NUM_CIRCLES-1:0]     rad_q;
   logic [1:0]                         mode_q;
   logic [NUM_CIRCLES-1:0]             mask_q;
   logic [KW-1:0]                      k_q;
   logic [COORD_W-1:0]                 x, y;
   logic                               sel;
   logic [CNT_W-1:0]                   count;

   logic [NUM_CIRCLES-1:0]             hit, m;
   logic [KW-1:0]                      pc;
   logic                               sel_next;

   for (genvar i = 0; i < NUM_CIRCLES; i++) begin : g_circ
      circle_hit #(.COORD_W(COORD_W)) u_hit (
         .cx  (cen_q[(2*i+1)*COORD_W +: COORD_W]),
         .cy  (cen_q[2*i*COORD_W +: COORD_W]),
         .r   (rad_q[i*COORD_W +: COORD_W]),
         .px  (x),
         .py  (y),
         .hit (hit[i])
      );
   end

   assign m = hit & mask_q;

   always_comb begin
      pc = '0;
      for (int i = 0; i < NUM_CIRCLES; i++) pc = pc + KW'(m[i]);
   end

   // An empty mask selects nothing, including EXACT with k=0.
   always_comb begin
      sel_next = 1'b0;
      case (mode_q)
         MODE_ANY:   sel_next = |m;
         MODE_ALL:   sel_next = (m == mask_q);
         MODE_ODD:   sel_next = ^m;
         MODE_EXACT: sel_next = (pc == k_q);
         default:    sel_next = 1'b0;
      endcase
      if (mask_q == '0) sel_next = 1'b0;
   end

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cen_q     <= '0;
         rad_q     <= '0;
         mode_q    <= MODE_ANY;
         mask_q    <= '0;
         k_q       <= '0;
         x         <= '0;
         y         <= '0;
         sel       <= 1'b0;
         count     <= '0;
         valid     <= 1'b0;
         candidate <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (en) begin
                  cen_q  <= central;
                  rad_q  <= radius;
                  mode_q <= mode;
                  mask_q <= mask;
                  k_q    <= k;
                  count  <= '0;
                  sel    <= 1'b0;
                  x      <= COORD_W'(1);
                  y      <= COORD_W'(1);
                  state  <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               // sel lags the scan by one point; DRAIN folds in the last one.
               sel   <= sel_next;
               count <= count + CNT_W'(sel);
               if (x == LAST) begin
                  x <= COORD_W'(1);
                  if (y == LAST) state <= ST_DRAIN;
                  else           y     <= y + COORD_W'(1);
               end else begin
                  x <= x + COORD_W'(1);
               end
            end
            ST_DRAIN: begin
               count <= count + CNT_W'(sel);
               state <= ST_DONE;
            end
            ST_DONE: begin
               candidate <= count;
               valid     <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_set_count_n.sv
// Self-checking bench for set_count_n with a point-by-point reference model.
module tb_set_count_n;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [23:0] central = '0;
   logic [11:0] radius = '0;
   logic [1:0]  mode = '0;
   logic [2:0]  mask = '0;
   logic [1:0]  k = '0;
   logic        busy, valid;
   logic [6:0]  candidate;

   int n_chk = 0;
   int n_fail = 0;
   int cx[3], cy[3], rr[3];

   always #5 clk = ~clk;

   set_count_n dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .central   (central),
      .radius    (radius),
      .mode      (mode),
      .mask      (mask),
      .k         (k),
      .busy      (busy),
      .valid     (valid),
      .candidate (candidate)
   );

   // Reference: walk the grid, test each selected circle with integer maths.
   function automatic int model(int md, int mk, int kk);
      int total = 0;
      for (int py = 1; py <= 8; py++)
         for (int px = 1; px <= 8; px++) begin
            int n = 0, h = 0;
            bit s;
            for (int i = 0; i < 3; i++)
               if ((mk >> i) & 1) begin
                  n++;
                  if ((px-cx[i])*(px-cx[i]) + (py-cy[i])*(py-cy[i]) <= rr[i]*rr[i]) h++;
               end
            case (md)
               0: s = (h > 0);
               1: s = (n > 0) && (h == n);
               2: s = (h % 2) == 1;
               default: s = (n > 0) && (h == kk);
            endcase
            total += int'(s);
         end
      return total;
   endfunction

   task automatic load();
      for (int i = 0; i < 3; i++) begin
         central[(2*i+1)*4 +: 4] = 4'(cx[i]);
         central[2*i*4 +: 4]     = 4'(cy[i]);
         radius[i*4 +: 4]        = 4'(rr[i]);
      end
   endtask

   task automatic set_all(int x, int y, int r);
      for (int i = 0; i < 3; i++) begin cx[i] = x; cy[i] = y; rr[i] = r; end
   endtask

   // Starts a job and returns the result plus edges from the en edge to valid.
   task automatic run_job(input int md, input int mk, input int kk,
                          output int cand, output int lat);
      load();
      @(negedge clk);
      mode = 2'(md); mask = 3'(mk); k = 2'(kk); en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      lat = -1; cand = -1;
      for (int n = 1; n <= 200; n++) begin
         @(posedge clk); #1;
         if (valid) begin lat = n; cand = int'(candidate); break; end
      end
   endtask

   task automatic test_reset();
      #1;
      n_chk++;
      if (busy !== 1'b0 || valid !== 1'b0 || candidate !== 7'd0) begin
         n_fail++;
         $display("FAIL reset: busy=%b valid=%b cand=%0d, want 0 0 0", busy, valid, candidate);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_any();
      int c, l;
      set_all(4, 4, 2);
      run_job(0, 1, 0, c, l);
      n_chk++;
      if (c !== 13) begin n_fail++; $display("FAIL any_count: got %0d want 13", c); end
      n_chk++;
      if (l !== 66) begin n_fail++; $display("FAIL any_latency: got %0d want 66", l); end
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL any_busy_at_valid: got %b want 0", busy); end
      @(posedge clk); #1;
      n_chk++;
      if (valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL any_after: valid=%b busy=%b want 0 0", valid, busy);
      end
   endtask

   task automatic test_all_odd();
      int c, l;
      cx[0] = 3; cy[0] = 3; rr[0] = 2;
      cx[1] = 5; cy[1] = 3; rr[1] = 2;
      cx[2] = 8; cy[2] = 8; rr[2] = 0;
      run_job(1, 3, 0, c, l);
      n_chk++;
      if (c !== 5) begin n_fail++; $display("FAIL all_count: got %0d want 5", c); end
      run_job(2, 3, 0, c, l);
      n_chk++;
      if (c !== 16) begin n_fail++; $display("FAIL odd_count: got %0d want 16", c); end
   endtask

   task automatic test_exact();
      int c, l;
      int exp_v[3] = '{5, 0, 0};
      int mks[3]   = '{7, 7, 3};
      int ks[3]    = '{3, 2, 3};
      set_all(4, 4, 1);
      for (int t = 0; t < 3; t++) begin
         run_job(3, mks[t], ks[t], c, l);
         n_chk++;
         if (c !== exp_v[t]) begin
            n_fail++; $display("FAIL exact_%0d: got %0d want %0d", t, c, exp_v[t]);
         end
      end
   endtask

   task automatic test_offgrid_busy();
      int c = -1, l = -1, extra = 0;
      set_all(1, 1, 3);
      load();
      @(negedge clk);
      mode = 2'd0; mask = 3'd1; k = 2'd0; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_accept: got %b want 1", busy); end
      for (int n = 1; n <= 200; n++) begin
         if (n < 12) begin
            @(negedge clk);
            en = ~en;
            central = 24'($urandom);
            @(posedge clk); #1;
         end else begin
            en = 1'b0;
            @(posedge clk); #1;
         end
         if (valid) begin l = n; c = int'(candidate); break; end
      end
      n_chk++;
      if (c !== 11 || l !== 66) begin
         n_fail++; $display("FAIL offgrid: got cand=%0d lat=%0d want 11 66", c, l);
      end
      repeat (100) begin
         @(posedge clk); #1;
         if (valid || busy) extra++;
      end
      n_chk++;
      if (extra !== 0) begin n_fail++; $display("FAIL no_queued_job: got %0d active cycles want 0", extra); end
   endtask

   task automatic test_mask_zero();
      int c, l;
      set_all(4, 4, 3);
      for (int md = 0; md < 4; md++) begin
         run_job(md, 0, 0, c, l);
         n_chk++;
         if (c !== 0) begin n_fail++; $display("FAIL mask0_mode%0d: got %0d want 0", md, c); end
      end
      set_all(8, 8, 0);
      run_job(0, 1, 0, c, l);
      n_chk++;
      if (c !== 1) begin n_fail++; $display("FAIL radius0: got %0d want 1", c); end
   endtask

   task automatic test_reset_mid();
      int c, l, seen = 0;
      set_all(4, 4, 2);
      load();
      @(negedge clk);
      mode = 2'd0; mask = 3'd1; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (busy !== 1'b0 || valid !== 1'b0 || candidate !== 7'd0) begin
         n_fail++;
         $display("FAIL reset_mid: busy=%b valid=%b cand=%0d want 0 0 0", busy, valid, candidate);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (80) begin
         @(posedge clk); #1;
         if (valid) seen++;
      end
      n_chk++;
      if (seen !== 0) begin n_fail++; $display("FAIL reset_abort: got %0d valid pulses want 0", seen); end
      run_job(0, 1, 0, c, l);
      n_chk++;
      if (c !== 13) begin n_fail++; $display("FAIL after_reset: got %0d want 13", c); end
   endtask

   task automatic test_back_to_back();
      int t0 = -1, t1 = -1, c0 = -1, c1 = -1, e0;
      set_all(4, 4, 2);
      load();
      @(negedge clk);
      mode = 2'd0; mask = 3'd1; en = 1'b1;
      e0 = model(0, 1, 0);
      for (int n = 1; n <= 300 && t1 < 0; n++) begin
         @(posedge clk); #1;
         if (valid) begin
            if (t0 < 0) begin
               t0 = n; c0 = int'(candidate);
               cx[0] = 2; cy[0] = 2; rr[0] = 3;
               load();
            end else begin
               t1 = n; c1 = int'(candidate);
            end
         end
      end
      en = 1'b0;
      n_chk++;
      if (t1 - t0 !== 67 || t0 < 0) begin
         n_fail++; $display("FAIL b2b_spacing: got %0d want 67", t1 - t0);
      end
      n_chk++;
      if (c0 !== e0 || c1 !== model(0, 1, 0)) begin
         n_fail++; $display("FAIL b2b_values: got %0d %0d want %0d %0d", c0, c1, e0, model(0, 1, 0));
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic test_random();
      int c, l, md, mk, kk, e;
      for (int t = 0; t < 24; t++) begin
         for (int i = 0; i < 3; i++) begin
            cx[i] = $urandom_range(1, 8);
            cy[i] = $urandom_range(1, 8);
            rr[i] = $urandom_range(0, 6);
         end
         md = $urandom_range(0, 3);
         mk = $urandom_range(0, 7);
         kk = $urandom_range(0, 3);
         e  = model(md, mk, kk);
         run_job(md, mk, kk, c, l);
         n_chk++;
         if (c !== e || l !== 66) begin
            n_fail++;
            $display("FAIL random_%0d: mode=%0d mask=%0d k=%0d got %0d lat %0d want %0d lat 66",
                     t, md, mk, kk, c, l, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_any();
      test_all_odd();
      test_exact();
      test_offgrid_busy();
      test_mask_zero();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
